// File: rtl/sprite_pkg.sv
// Shared sizing defaults, width helpers and the built-in sprite image for the sprite ROM.
package sprite_pkg;
  localparam int SPR_W_DEF      = 16;
  localparam int SPR_H_DEF      = 16;
  localparam int FRAMES_DEF     = 4;
  localparam int BPP_DEF        = 1;
  localparam int FRAME_HOLD_DEF = 8;
  localparam int TRANSP_KEY_DEF = 1;

  // Index width that stays >= 1 so single-entry spaces still get a real port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_width(input int depth);
    return idx_width(depth);
  endfunction

  // Frame-major image: pixel(f,r,c) = (r + c + f) mod 2^bpp (checkerboard that shifts per frame).
  function automatic int img_pixel(input int a, input int w, input int pix, input int bpp);
    return ((a % w) + ((a % pix) / w) + (a / pix)) % (1 << bpp);
  endfunction
endpackage

// File: rtl/sprite_rom_bram.sv
// Synchronous-read sprite ROM; holds its last read word while en is low.
module sprite_rom_bram
  import sprite_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int BPP   = 1,
  parameter int SPR_W = 16,
  parameter int PIX   = 256,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic           clk,
  input  logic           en,
  input  logic [AW-1:0]  addr,
  output logic [BPP-1:0] dout
);
  (* rom_style = "block" *) logic [BPP-1:0] rom [DEPTH];
  logic [BPP-1:0] rd_q, rd_d;

  for (genvar g = 0; g < DEPTH; g++) begin : g_img
    assign rom[g] = BPP'(img_pixel(g, SPR_W, PIX, BPP));
  end

  always_comb rd_d = en ? rom[addr] : rd_q;

  always_ff @(posedge clk) rd_q <= rd_d;

  assign dout = rd_q;
endmodule

// File: rtl/sprite_anim_rom.sv
// Animated sprite ROM: mirror/range address stage, frame sequencer, 2-cycle registered pixel read.
module sprite_anim_rom
  import sprite_pkg::*;
#(
  parameter int SPR_W      = SPR_W_DEF,
  parameter int SPR_H      = SPR_H_DEF,
  parameter int FRAMES     = FRAMES_DEF,
  parameter int BPP        = BPP_DEF,
  parameter int FRAME_HOLD = FRAME_HOLD_DEF,
  parameter int TRANSP_KEY = TRANSP_KEY_DEF,
  localparam int RW = $clog2(SPR_H),
  localparam int CW = $clog2(SPR_W),
  localparam int FW = idx_width(FRAMES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  input  logic [RW-1:0]  row,
  input  logic [CW-1:0]  col,
  input  logic           flip_h,
  input  logic           flip_v,
  input  logic           anim_en,
  input  logic           frame_tick,
  input  logic           frame_load,
  input  logic [FW-1:0]  frame_sel,
  output logic           pix_valid,
  output logic [BPP-1:0] pix_data,
  output logic           pix_transp,
  output logic [FW-1:0]  frame_idx
);
  localparam int PIX   = SPR_W * SPR_H;
  localparam int DEPTH = FRAMES * PIX;
  localparam int AW    = addr_width(DEPTH);
  localparam int HW    = idx_width(FRAME_HOLD);
  localparam logic [BPP-1:0] KEY = BPP'(TRANSP_KEY);

  logic [1:0]     vld_pipe_q, vld_pipe_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           oor_q, oor_d;
  logic           oor1_q, oor1_d;
  logic [FW-1:0]  frame_q, frame_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [RW-1:0]  row_m;
  logic [CW-1:0]  col_m;
  logic [FW-1:0]  sel_c;
  logic [BPP-1:0] rom_dout;

  always_comb begin
    row_m  = flip_v ? RW'(SPR_H - 1) - row : row;
    col_m  = flip_h ? CW'(SPR_W - 1) - col : col;
    // Range is judged on the raw coordinates; a bad pixel reads entry 0 and is masked later.
    oor_d  = ({1'b0, row} >= (RW+1)'(SPR_H)) | ({1'b0, col} >= (CW+1)'(SPR_W));
    addr_d = oor_d ? '0
           : AW'(frame_q) * AW'(PIX) + AW'(row_m) * AW'(SPR_W) + AW'(col_m);

    vld_pipe_d = {vld_pipe_q[0], req_valid};
    oor1_d     = vld_pipe_q[0] ? oor_q : oor1_q;

    sel_c   = (frame_sel > FW'(FRAMES - 1)) ? FW'(FRAMES - 1) : frame_sel;
    frame_d = frame_q;
    hold_d  = hold_q;
    if (frame_load) begin
      frame_d = sel_c;
      hold_d  = '0;
    end else if (anim_en && frame_tick) begin
      if (hold_q == HW'(FRAME_HOLD - 1)) begin
        hold_d  = '0;
        frame_d = (frame_q == FW'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      addr_q     <= '0;
      oor_q      <= 1'b1;
      oor1_q     <= 1'b1;
      frame_q    <= '0;
      hold_q     <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      oor1_q     <= oor1_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
    end
  end

  sprite_rom_bram #(
    .DEPTH (DEPTH),
    .BPP   (BPP),
    .SPR_W (SPR_W),
    .PIX   (PIX),
    .AW    (AW)
  ) u_rom (
    .clk  (clk),
    .en   (vld_pipe_q[0]),
    .addr (addr_q),
    .dout (rom_dout)
  );

  // Read word and range flag only update on valid slots, so idle cycles hold the last pixel.
  assign pix_valid  = vld_pipe_q[1];
  assign pix_data   = oor1_q ? KEY : rom_dout;
  assign pix_transp = oor1_q | (rom_dout == KEY);
  assign frame_idx  = frame_q;
endmodule

// File: tb/tb_sprite_anim_rom.sv
// Randomized self-checking bench for sprite_anim_rom against a tick-count animation model.
module tb_sprite_anim_rom;
  localparam int W = 16, H = 16, F = 4, HOLD = 8, KEY = 1;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       req_valid = 0;
  logic [3:0] row = 0, col = 0;
  logic       flip_h = 0, flip_v = 0, anim_en = 0, frame_tick = 0, frame_load = 0;
  logic [1:0] frame_sel = 0;
  logic       pix_valid;
  logic [0:0] pix_data;
  logic       pix_transp;
  logic [1:0] frame_idx;

  sprite_anim_rom dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .row(row), .col(col),
    .flip_h(flip_h), .flip_v(flip_v), .anim_en(anim_en), .frame_tick(frame_tick),
    .frame_load(frame_load), .frame_sel(frame_sel), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_transp(pix_transp), .frame_idx(frame_idx)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  // Model: frame = (base + enabled ticks since last load/reset / HOLD) mod F.
  int base = 0, nticks = 0;
  int p_v = 0, p_d = 0;      // request currently in stage 0
  int last_d = KEY;          // last delivered pixel value

  function automatic int cur_frame();
    return (base + nticks / HOLD) % F;
  endfunction

  function automatic int img(int f, int r, int c);
    return (r + c + f) % 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check 1 unit after posedge, return at next negedge.
  task automatic step(input int rv, input int r, input int c, input int fh, input int fv,
                      input int en, input int tk, input int ld, input int sel);
    int e_d;
    req_valid = rv[0]; row = r[3:0]; col = c[3:0]; flip_h = fh[0]; flip_v = fv[0];
    anim_en = en[0]; frame_tick = tk[0]; frame_load = ld[0]; frame_sel = sel[1:0];
    e_d = img(cur_frame(), fv ? H - 1 - r : r, fh ? W - 1 - c : c);
    @(posedge clk); #1;
    if (ld != 0) begin
      base = (sel > F - 1) ? F - 1 : sel;
      nticks = 0;
    end else if (en != 0 && tk != 0) nticks++;
    if (p_v != 0) last_d = p_d;
    chk("pix_valid", 32'(pix_valid), 32'(p_v));
    chk("pix_data", 32'(pix_data), 32'(last_d));
    chk("pix_transp", 32'(pix_transp), 32'(last_d == KEY));
    chk("frame_idx", 32'(frame_idx), 32'(cur_frame()));
    p_v = rv; p_d = e_d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    base = 0; nticks = 0; p_v = 0; last_d = KEY;
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_pix_data", 32'(pix_data), KEY);
    chk("rst_pix_transp", 32'(pix_transp), 1);
    chk("rst_frame_idx", 32'(frame_idx), 0);
    @(negedge clk);
    req_valid = 0;
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Raster of frame 0
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        step(1, r, c, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Mirrored corner, then animation: 8 ticks advance, 32 wrap, disabled ticks frozen
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(1, i % 16, (i * 3) % 16, i % 2, 0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, i % 16, i % 16, 0, 1, 0, 1, 0, 0);

    // Load with simultaneous tick; then request on the very edge of a frame advance
    step(1, 3, 4, 0, 0, 1, 1, 1, 3);
    step(1, 3, 4, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 4) != 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 19) == 0) ? 1 : 0,
           $urandom_range(0, 3));

    // Reset with requests in flight: nothing may emerge afterwards
    step(1, 1, 2, 0, 0, 1, 1, 0, 0);
    step(1, 5, 6, 0, 0, 1, 1, 0, 0);
    req_valid = 1;
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 9, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
